// File: rtl/invaders_formation.sv
// Invader formation: marches across the playfield, descends at each edge,
// and clears invaders on player hits until the game leaves PLAYING.
module invaders_formation #(
  parameter int STEP_FRAMES = 30,
  parameter int COL_MAX     = 12,
  parameter int LAST_LINE   = 13
) (
  input  logic        i_clk_25MHz,
  input  logic        i_reset,
  input  logic [1:0]  i_gameplay,
  input  logic        i_frame_tick,
  input  logic        i_hit_valid,
  input  logic [4:0]  i_hit_index,
  output logic [19:0] o_invaders_array,
  output logic [3:0]  o_invaders_line,
  output logic [3:0]  o_invaders_col,
  output logic        o_direction,
  output logic        o_hit_ack,
  output logic        o_step
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
  localparam logic [3:0] CMAX      = 4'(COL_MAX);
  localparam logic [3:0] LMAX      = 4'(LAST_LINE);

  typedef enum logic {
    MARCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic        active;
  logic [7:0]  frame_cnt;
  logic [19:0] hit_mask;
  logic        hit_ok;
  logic        step_now;
  logic        at_edge;

  always_ff @(posedge i_clk_25MHz or negedge i_reset) begin
    if (!i_reset) state <= MARCH;
    else          state <= state_nx;
  end

  // Leaving PLAYING freezes the formation on that same edge.
  always_comb begin
    state_nx = state;
    active   = 1'b0;
    case (state)
      MARCH: begin
        if (i_gameplay != 2'b00) state_nx = HALTED;
        else                     active   = 1'b1;
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = HALTED;
    endcase
  end

  // Indices 20..31 shift the one out of range, giving an empty mask.
  assign hit_mask = 20'd1 << i_hit_index;
  assign hit_ok   = active & i_hit_valid
                  & (|(o_invaders_array & hit_mask));
  assign step_now = active & i_frame_tick
                  & (frame_cnt == STEP_LAST);
  assign at_edge  = o_direction ? (o_invaders_col == 4'd0)
                                : (o_invaders_col == CMAX);

  always_ff @(posedge i_clk_25MHz or negedge i_reset) begin
    if (!i_reset) begin
      o_invaders_array <= 20'hFFFFF;
      o_invaders_line  <= 4'd0;
      o_invaders_col   <= 4'd0;
      o_direction      <= 1'b0;
      o_hit_ack        <= 1'b0;
      o_step           <= 1'b0;
      frame_cnt        <= 8'd0;
    end else begin
      o_step    <= step_now;
      o_hit_ack <= hit_ok;
      if (hit_ok)
        o_invaders_array <= o_invaders_array & ~hit_mask;
      if (active && i_frame_tick)
        frame_cnt <= step_now ? 8'd0 : frame_cnt + 8'd1;
      if (step_now) begin
        if (at_edge) begin
          if (o_invaders_line != LMAX)
            o_invaders_line <= o_invaders_line + 4'd1;
          o_direction <= ~o_direction;
        end else if (o_direction) begin
          o_invaders_col <= o_invaders_col - 4'd1;
        end else begin
          o_invaders_col <= o_invaders_col + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_invaders_formation.sv
// Bench for invaders_formation: randomized stimulus against a
// frame-counting reference model of the formation's marching rules.
module tb_invaders_formation;

  localparam int SF = 30;
  localparam int CM = 12;
  localparam int LL = 13;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_gameplay = 2'b00;
  logic        i_frame_tick = 1'b0;
  logic        i_hit_valid = 1'b0;
  logic [4:0]  i_hit_index = 5'd0;
  logic [19:0] o_invaders_array;
  logic [3:0]  o_invaders_line;
  logic [3:0]  o_invaders_col;
  logic        o_direction;
  logic        o_hit_ack;
  logic        o_step;

  int n_cmp = 0;
  int n_bad = 0;

  invaders_formation dut (
    .i_clk_25MHz      (clk),
    .i_reset          (i_reset),
    .i_gameplay       (i_gameplay),
    .i_frame_tick     (i_frame_tick),
    .i_hit_valid      (i_hit_valid),
    .i_hit_index      (i_hit_index),
    .o_invaders_array (o_invaders_array),
    .o_invaders_line  (o_invaders_line),
    .o_invaders_col   (o_invaders_col),
    .o_direction      (o_direction),
    .o_hit_ack        (o_hit_ack),
    .o_step           (o_step)
  );

  always #20 clk = ~clk;

  // Reference model: plain integers updated once per rising edge.
  bit [19:0] m_arr;
  int        m_line, m_col, m_frames;
  bit        m_dir, m_step, m_ack, m_halt;

  function automatic void model_reset();
    m_arr = 20'hFFFFF;
    m_line = 0; m_col = 0; m_frames = 0;
    m_dir = 0; m_step = 0; m_ack = 0; m_halt = 0;
  endfunction

  function automatic void model_edge(bit t, bit hv, int hi,
                                     logic [1:0] gp);
    m_step = 0;
    m_ack  = 0;
    if (m_halt || gp != 2'b00) begin
      m_halt = 1;
      return;
    end
    if (hv && hi < 20 && m_arr[hi]) begin
      m_arr[hi] = 1'b0;
      m_ack = 1;
    end
    if (t) begin
      m_frames++;
      if (m_frames == SF) begin
        m_frames = 0;
        m_step = 1;
        if (!m_dir && m_col < CM) m_col++;
        else if (m_dir && m_col > 0) m_col--;
        else begin
          if (m_line < LL) m_line++;
          m_dir = ~m_dir;
        end
      end
    end
  endfunction

  function automatic logic [30:0] m_vec();
    return {m_arr, 4'(m_line), 4'(m_col), m_dir, m_step, m_ack};
  endfunction

  wire [30:0] d_vec = {o_invaders_array, o_invaders_line,
                       o_invaders_col, o_direction, o_step, o_hit_ack};

  task automatic cyc(input bit t, input bit hv, input int hi,
                     input logic [1:0] gp);
    @(negedge clk);
    i_frame_tick = t;
    i_hit_valid  = hv;
    i_hit_index  = 5'(hi);
    i_gameplay   = gp;
    @(posedge clk);
    model_edge(t, hv, hi, gp);
    #1;
  endtask

  task automatic idle_inputs();
    i_frame_tick = 0;
    i_hit_valid  = 0;
    i_hit_index  = 0;
    i_gameplay   = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    i_reset = 0;
    model_reset();
    #5;
    i_reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    i_reset = 0;
    model_reset();
    #1;
    n_cmp++;
    if (d_vec !== {20'hFFFFF, 4'd0, 4'd0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset act=%h exp=%h", d_vec,
               {20'hFFFFF, 4'd0, 4'd0, 3'b000});
    end
    #4;
    i_reset = 1;
  endtask

  task automatic test_first_step();
    int st = 0;
    do_reset();
    for (int i = 0; i < SF; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cyc(0, 0, 0, 2'b00);
        st += int'(o_step);
      end
      cyc(1, 0, 0, 2'b00);
      st += int'(o_step);
      n_cmp++;
      if (d_vec !== m_vec()) begin
        n_bad++;
        $display("FAIL first_step act=%h exp=%h", d_vec, m_vec());
      end
    end
    n_cmp++;
    if (st !== 1 || o_invaders_col !== 4'd1 ||
        o_invaders_line !== 4'd0 || o_direction !== 1'b0) begin
      n_bad++;
      $display("FAIL first_step_pos steps=%0d col=%0d line=%0d dir=%0d exp 1/1/0/0",
               st, o_invaders_col, o_invaders_line, o_direction);
    end
  endtask

  task automatic test_edge_turn();
    for (int i = 0; i < (CM - 1) * SF; i++) cyc(1, 0, 0, 2'b00);
    n_cmp++;
    if (o_invaders_col !== 4'd12 || o_invaders_line !== 4'd0 ||
        o_direction !== 1'b0) begin
      n_bad++;
      $display("FAIL at_right col=%0d line=%0d dir=%0d exp 12/0/0",
               o_invaders_col, o_invaders_line, o_direction);
    end
    for (int i = 0; i < SF; i++) cyc(1, 0, 0, 2'b00);
    n_cmp++;
    if (o_invaders_col !== 4'd12 || o_invaders_line !== 4'd1 ||
        o_direction !== 1'b1 || d_vec !== m_vec()) begin
      n_bad++;
      $display("FAIL descend col=%0d line=%0d dir=%0d exp 12/1/1",
               o_invaders_col, o_invaders_line, o_direction);
    end
  endtask

  task automatic test_hits();
    int acks = 0;
    do_reset();
    cyc(0, 1, 5, 2'b00);
    acks += int'(o_hit_ack);
    cyc(0, 1, 5, 2'b00);
    acks += int'(o_hit_ack);
    cyc(0, 0, 0, 2'b00);
    acks += int'(o_hit_ack);
    n_cmp++;
    if (o_invaders_array !== 20'hFFFDF || acks !== 1) begin
      n_bad++;
      $display("FAIL hit5 arr=%h acks=%0d exp FFFDF/1",
               o_invaders_array, acks);
    end
    cyc(0, 1, 25, 2'b00);
    n_cmp++;
    if (o_invaders_array !== 20'hFFFDF || o_hit_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL hit25 arr=%h ack=%0d exp FFFDF/0",
               o_invaders_array, o_hit_ack);
    end
  endtask

  task automatic test_hit_with_step();
    do_reset();
    for (int i = 0; i < SF - 1; i++) cyc(1, 0, 0, 2'b00);
    cyc(1, 1, 0, 2'b00);
    n_cmp++;
    if (o_invaders_array !== 20'hFFFFE || o_invaders_col !== 4'd1 ||
        o_step !== 1'b1 || o_hit_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL hit_step arr=%h col=%0d step=%0d ack=%0d exp FFFFE/1/1/1",
               o_invaders_array, o_invaders_col, o_step, o_hit_ack);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit t  = ($urandom_range(0, 1) == 1);
      bit hv = ($urandom_range(0, 3) == 0);
      int hi = int'($urandom_range(0, 31));
      cyc(t, hv, hi, 2'b00);
      n_cmp++;
      if (d_vec !== m_vec()) begin
        n_bad++;
        $display("FAIL random[%0d] act=%h exp=%h", i, d_vec, m_vec());
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 50; i++) cyc(1, 0, 0, 2'b00);
    cyc(0, 0, 0, 2'b10);
    for (int i = 0; i < 60; i++) begin
      cyc(1, ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, 19)), 2'b00);
      n_cmp++;
      if (d_vec !== m_vec() || o_step !== 1'b0 ||
          o_hit_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL halted[%0d] act=%h exp=%h", i, d_vec, m_vec());
      end
    end
    do_reset();
    for (int i = 0; i < SF; i++) cyc(1, 0, 0, 2'b00);
    n_cmp++;
    if (o_invaders_col !== 4'd1 || d_vec !== m_vec()) begin
      n_bad++;
      $display("FAIL unhalt act=%h exp=%h", d_vec, m_vec());
    end
  endtask

  task automatic test_reset_discard();
    do_reset();
    for (int i = 0; i < SF - 1; i++) cyc(1, 0, 0, 2'b00);
    cyc(1, 1, 3, 2'b00);
    n_cmp++;
    if (o_step !== 1'b1 || o_hit_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_discard step=%0d ack=%0d exp 1/1",
               o_step, o_hit_ack);
    end
    #3;
    idle_inputs();
    i_reset = 0;
    model_reset();
    #1;
    n_cmp++;
    if (o_step !== 1'b0 || o_hit_ack !== 1'b0 ||
        o_invaders_array !== 20'hFFFFF) begin
      n_bad++;
      $display("FAIL discard step=%0d ack=%0d arr=%h exp 0/0/FFFFF",
               o_step, o_hit_ack, o_invaders_array);
    end
    @(negedge clk);
    i_reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 2'b00);
      n_cmp++;
      if (d_vec !== m_vec()) begin
        n_bad++;
        $display("FAIL post_discard act=%h exp=%h", d_vec, m_vec());
      end
    end
  endtask

  task automatic test_saturate();
    int  n13 = 0;
    int  pl;
    bit  pd;
    do_reset();
    for (int c = 0; c < 8000 && n13 < 2; c++) begin
      pl = m_line;
      pd = m_dir;
      cyc(1, 0, 0, 2'b00);
      if (m_step && pl == LL && m_line == LL && pd != m_dir) n13++;
      if (d_vec !== m_vec()) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sat_track act=%h exp=%h", d_vec, m_vec());
      end
    end
    n_cmp++;
    if (n13 !== 2 || o_invaders_line !== 4'd13 ||
        o_direction !== m_dir || d_vec !== m_vec()) begin
      n_bad++;
      $display("FAIL saturate descends=%0d line=%0d dir=%0d exp 2/13/%0d",
               n13, o_invaders_line, o_direction, m_dir);
    end
    #5;
    idle_inputs();
    i_reset = 0;
    model_reset();
    #1;
    n_cmp++;
    if (d_vec !== {20'hFFFFF, 4'd0, 4'd0, 3'b000}) begin
      n_bad++;
      $display("FAIL async_reset act=%h exp=%h", d_vec,
               {20'hFFFFF, 4'd0, 4'd0, 3'b000});
    end
    @(negedge clk);
    i_reset = 1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_step();
    test_edge_turn();
    test_hits();
    test_hit_with_step();
    test_random();
    test_halt();
    test_reset_discard();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
